// File: rtl/cla_share_arb_if.sv
// Request/result bundle between the partial-sum producers, the shared adder
// arbiter and the accumulation stage.
interface cla_share_arb_if #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*24-1:0] req_a;
    logic [N_REQ*24-1:0] req_b;
    logic [N_REQ-1:0]    req_ci;
    logic                res_valid;
    logic                res_ready;
    logic [23:0]         res_sum;
    logic                res_co;
    logic                res_ovf;
    logic [IDW-1:0]      res_id;

    modport slave (
        input  req_valid, req_a, req_b, req_ci, res_ready,
        output req_ready, res_valid, res_sum, res_co, res_ovf, res_id
    );

    modport master (
        output req_valid, req_a, req_b, req_ci, res_ready,
        input  req_ready, res_valid, res_sum, res_co, res_ovf, res_id
    );
endinterface

// File: rtl/cla_share_arb.sv
// Round-robin sharing of one 24-bit carry-lookahead adder among N_REQ
// requesters, with a single-entry registered result stage.

module s_cla (
    input  logic [23:0] a_i,
    input  logic [23:0] b_i,
    input  logic        ci_i,
    output logic [23:0] s_o,
    output logic        co_o,
    output logic        ovf_o
);
    logic [23:0] g_s;
    logic [23:0] p_s;
    logic [5:0]  grp_g_s;
    logic [5:0]  grp_p_s;
    logic [6:0]  grp_c_s;
    logic [24:0] c_s;

    // Two-level lookahead: 4-bit group generate/propagate, then carries per bit.
    always_comb begin
        g_s     = a_i & b_i;
        p_s     = a_i ^ b_i;
        grp_g_s = 6'd0;
        grp_p_s = 6'h3F;
        grp_c_s = 7'd0;
        c_s     = 25'd0;
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < 4; j++) begin
                grp_g_s[k] = g_s[4*k+j] | (p_s[4*k+j] & grp_g_s[k]);
                grp_p_s[k] = grp_p_s[k] & p_s[4*k+j];
            end
        end
        grp_c_s[0] = ci_i;
        for (int k = 0; k < 6; k++) begin
            grp_c_s[k+1] = grp_g_s[k] | (grp_p_s[k] & grp_c_s[k]);
        end
        for (int k = 0; k < 6; k++) begin
            c_s[4*k] = grp_c_s[k];
            for (int j = 0; j < 3; j++) begin
                c_s[4*k+j+1] = g_s[4*k+j] | (p_s[4*k+j] & c_s[4*k+j]);
            end
        end
        c_s[24] = grp_c_s[6];
    end

    assign s_o   = p_s ^ c_s[23:0];
    assign co_o  = c_s[24];
    assign ovf_o = (a_i[23] == b_i[23]) & (s_o[23] != a_i[23]);
endmodule

module cla_share_arb_chk #(
    parameter int N_REQ = 4
) (
    input logic                clk,
    input logic                rst,
    input logic [N_REQ-1:0]    req_valid,
    input logic [N_REQ-1:0]    req_ready,
    input logic [N_REQ*24-1:0] req_a,
    input logic [N_REQ*24-1:0] req_b,
    input logic [N_REQ-1:0]    req_ci
);
    for (genvar i = 0; i < N_REQ; i++) begin : g_hold
        a_req_hold: assert property (@(posedge clk) disable iff (rst)
            (req_valid[i] && !req_ready[i]) |=>
            (req_valid[i] && $stable(req_a[24*i +: 24]) &&
             $stable(req_b[24*i +: 24]) && $stable(req_ci[i])));
    end

    a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(req_ready));
endmodule

module cla_share_arb #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input logic           clk,
    input logic           rst,
    cla_share_arb_if.slave bus
);
    typedef enum logic [0:0] {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [23:0]    sum_q, sum_d;
    logic           co_q, co_d;
    logic           ovf_q, ovf_d;
    logic [IDW-1:0] id_q, id_d;

    logic [IDW-1:0] gnt_s;
    logic [IDW:0]   scan_s;
    logic [IDW:0]   wrap_s;
    logic           any_s;
    logic           can_accept_s;
    logic           xfer_s;
    logic [23:0]    a_arr_s [N_REQ];
    logic [23:0]    b_arr_s [N_REQ];
    logic [23:0]    add_s_s;
    logic           add_co_s;
    logic           add_ovf_s;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign a_arr_s[i] = bus.req_a[24*i +: 24];
        assign b_arr_s[i] = bus.req_b[24*i +: 24];
    end

    // Scan from the farthest offset down so the nearest valid requester to ptr wins.
    always_comb begin
        gnt_s  = '0;
        scan_s = '0;
        wrap_s = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_s = {1'b0, ptr_q} + (IDW+1)'(k);
            wrap_s = (scan_s >= (IDW+1)'(N_REQ)) ? (scan_s - (IDW+1)'(N_REQ)) : scan_s;
            gnt_s  = bus.req_valid[wrap_s[IDW-1:0]] ? wrap_s[IDW-1:0] : gnt_s;
        end
    end

    assign any_s         = |bus.req_valid;
    assign can_accept_s  = ~rst & ((state_q == ST_EMPTY) | bus.res_ready);
    assign xfer_s        = can_accept_s & any_s;
    assign bus.req_ready = xfer_s ? (N_REQ'(1) << gnt_s) : '0;

    s_cla u_cla (
        .a_i   (a_arr_s[gnt_s]),
        .b_i   (b_arr_s[gnt_s]),
        .ci_i  (bus.req_ci[gnt_s]),
        .s_o   (add_s_s),
        .co_o  (add_co_s),
        .ovf_o (add_ovf_s)
    );

    // Output-stage occupancy: a transfer always fills; a drain without refill empties.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: state_d = xfer_s ? ST_FULL : ST_EMPTY;
            ST_FULL: begin
                if (xfer_s) begin
                    state_d = ST_FULL;
                end else if (bus.res_ready) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Result fields and pointer load only on a transfer; otherwise they hold.
    always_comb begin
        sum_d = sum_q;
        co_d  = co_q;
        ovf_d = ovf_q;
        id_d  = id_q;
        ptr_d = ptr_q;
        if (xfer_s) begin
            sum_d = add_s_s;
            co_d  = add_co_s;
            ovf_d = add_ovf_s;
            id_d  = gnt_s;
            ptr_d = (gnt_s == IDW'(N_REQ - 1)) ? '0 : (gnt_s + IDW'(1));
        end else begin
            ptr_d = ptr_q;
        end
    end

    // State and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            ptr_q   <= '0;
            sum_q   <= 24'd0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
            id_q    <= id_d;
        end
    end

    assign bus.res_valid = (state_q == ST_FULL);
    assign bus.res_sum   = sum_q;
    assign bus.res_co    = co_q;
    assign bus.res_ovf   = ovf_q;
    assign bus.res_id    = id_q;

    cla_share_arb_chk #(.N_REQ(N_REQ)) u_chk (
        .clk       (clk),
        .rst       (rst),
        .req_valid (bus.req_valid),
        .req_ready (bus.req_ready),
        .req_a     (bus.req_a),
        .req_b     (bus.req_b),
        .req_ci    (bus.req_ci)
    );
endmodule

// File: tb/tb_cla_share_arb.sv
// Scoreboard bench for cla_share_arb: a reference arbiter/adder model pushes
// expected results at grant time and compares them when the result appears.
module tb_cla_share_arb;
    localparam int N   = 4;
    localparam int IDW = 2;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [23:0]    s;
        logic           co;
        logic           ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cla_share_arb_if #(.N_REQ(N), .IDW(IDW)) bus ();

    cla_share_arb #(.N_REQ(N), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [N-1:0]   rv;
    logic [23:0]    ra [N];
    logic [23:0]    rb [N];
    logic [N-1:0]   rci;
    int             left [N];
    logic           rr;

    exp_t           exp_q [$];
    logic           m_full;
    int             m_ptr;
    logic [23:0]    m_sum;
    logic           m_co;
    logic           m_ovf;
    logic [IDW-1:0] m_id;
    int             ids [3];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]      = rv[i];
            bus.req_a[24*i +: 24] = ra[i];
            bus.req_b[24*i +: 24] = rb[i];
            bus.req_ci[i]         = rci[i];
        end
        bus.res_ready = rr;
    endtask

    task automatic new_req(input int i, input int cnt, input logic [23:0] a,
                           input logic [23:0] b, input logic ci);
        rv[i]   = 1'b1;
        ra[i]   = a;
        rb[i]   = b;
        rci[i]  = ci;
        left[i] = cnt;
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_ptr  = 0;
        m_sum  = 24'd0;
        m_co   = 1'b0;
        m_ovf  = 1'b0;
        m_id   = '0;
        exp_q.delete();
    endtask

    task automatic check_outputs();
        check_eq("res_valid", 32'(bus.res_valid), 32'(m_full));
        check_eq("res_sum",   32'(bus.res_sum),   32'(m_sum));
        check_eq("res_co",    32'(bus.res_co),    32'(m_co));
        check_eq("res_ovf",   32'(bus.res_ovf),   32'(m_ovf));
        check_eq("res_id",    32'(bus.res_id),    32'(m_id));
    endtask

    // One clock: predict the grant, check req_ready, then check the registered result.
    task automatic step();
        int           g;
        logic         can;
        logic         xfer;
        logic [N-1:0] exp_rdy;
        logic [24:0]  t;
        exp_t         e;
        drive();
        #1;
        can = !m_full || rr;
        g   = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (g < 0 && rv[idx]) g = idx;
        end
        xfer    = can && (g >= 0);
        exp_rdy = '0;
        if (xfer) exp_rdy[g] = 1'b1;
        check_eq("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        if (xfer) begin
            t     = {1'b0, ra[g]} + {1'b0, rb[g]} + 25'(rci[g]);
            e.id  = IDW'(g);
            e.s   = t[23:0];
            e.co  = t[24];
            e.ovf = (ra[g][23] == rb[g][23]) && (t[23] != ra[g][23]);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (xfer) begin
            e      = exp_q.pop_front();
            m_sum  = e.s;
            m_co   = e.co;
            m_ovf  = e.ovf;
            m_id   = e.id;
            m_full = 1'b1;
            m_ptr  = (g + 1) % N;
            left[g]--;
            if (left[g] > 0) begin
                ra[g]  = 24'($urandom);
                rb[g]  = 24'($urandom);
                rci[g] = 1'($urandom);
            end else begin
                rv[g] = 1'b0;
            end
        end else if (m_full && rr) begin
            m_full = 1'b0;
        end
        check_outputs();
        @(negedge clk);
    endtask

    initial begin
        rv  = '0;
        rci = '0;
        rr  = 1'b0;
        for (int i = 0; i < N; i++) begin
            ra[i]   = 24'd0;
            rb[i]   = 24'd0;
            left[i] = 0;
        end
        model_reset();

        // Reset state, with a request present to show req_ready is forced low.
        rv[0] = 1'b1;
        drive();
        #12;
        check_outputs();
        check_eq("rst_ready", 32'(bus.req_ready), 32'd0);
        rv = '0;
        drive();
        @(negedge clk);
        rst = 1'b0;

        // Round-robin: all requesters valid, result drained every cycle.
        rr = 1'b1;
        for (int i = 0; i < N; i++) new_req(i, 3, 24'($urandom), 24'($urandom), 1'($urandom));
        for (int k = 0; k < 12; k++) begin
            step();
            check_eq("rr_seq", 32'(bus.res_id), 32'(k % 4));
        end
        step();

        // Positive overflow from requester 2.
        new_req(2, 1, 24'h7FFFFF, 24'h000001, 1'b0);
        step();
        check_eq("ovf_sum", 32'(bus.res_sum), 32'h800000);
        check_eq("ovf_co",  32'(bus.res_co),  32'd0);
        check_eq("ovf_flag", 32'(bus.res_ovf), 32'd1);
        check_eq("ovf_id",  32'(bus.res_id),  32'd2);
        step();

        // Carry-out without overflow, carry-in included.
        new_req(1, 1, 24'hFFFFFF, 24'h000001, 1'b1);
        step();
        check_eq("co_sum",  32'(bus.res_sum), 32'h000001);
        check_eq("co_co",   32'(bus.res_co),  32'd1);
        check_eq("co_flag", 32'(bus.res_ovf), 32'd0);
        step();

        // Backpressure: hold for five cycles, then drain with no bubble.
        rr = 1'b0;
        for (int i = 0; i < N; i++) new_req(i, 2, 24'($urandom), 24'($urandom), 1'($urandom));
        for (int k = 0; k < 6; k++) step();
        rr = 1'b1;
        for (int k = 0; k < 9; k++) step();

        // Sparse wrap: bring ptr to 1, then only requesters 3 and 0.
        new_req(0, 1, 24'h123456, 24'h654321, 1'b0);
        step();
        step();
        new_req(3, 2, 24'h800000, 24'h800000, 1'b0);
        new_req(0, 1, 24'h000010, 24'hFFFFF0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            ids[k] = int'(bus.res_id);
        end
        check_eq("wrap_0", 32'(ids[0]), 32'd3);
        check_eq("wrap_1", 32'(ids[1]), 32'd0);
        check_eq("wrap_2", 32'(ids[2]), 32'd3);
        step();

        // Reset mid-stream while holding a result with ptr at 2.
        rr = 1'b0;
        new_req(1, 1, 24'h0000AA, 24'h000055, 1'b0);
        step();
        new_req(3, 1, 24'h111111, 24'h222222, 1'b0);
        new_req(1, 1, 24'h333333, 24'h444444, 1'b1);
        drive();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check_eq("midrst_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rr  = 1'b1;
        step();
        check_eq("post_rst_id", 32'(bus.res_id), 32'd1);
        step();
        step();

        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cla_share_arb.md
# cla_share_arb

Round-robin scheduler that shares one 24-bit signed carry-lookahead adder (s_cla, instantiated internally) among N_REQ requesters. Each requester presents an operand pair and carry-in over a valid/ready handshake. The block grants one requester per cycle and registers the sum with its requester ID in a single-entry output stage that honours downstream backpressure. It sits between the DCIM partial-sum producers and the accumulation stage, so the design needs only one adder instead of one per column group.

## Interface
- N_REQ, 4, number of requesters; legal range 2..8
- IDW, $clog2(N_REQ), width of requester ID
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept; one-hot or zero
- req_a  in  N_REQ*24  signed operand A; requester i occupies bits [24*i+23:24*i]
- req_b  in  N_REQ*24  signed operand B; same packing as req_a
- req_ci  in  N_REQ  carry-in per requester
- res_valid  out  1  result register holds valid data
- res_ready  in  1  downstream accepts result
- res_sum  out  24  signed sum a+b+ci, mod 2^24
- res_co  out  1  unsigned carry-out of bit 23
- res_ovf  out  1  signed overflow flag
- res_id  out  IDW  index of the requester that produced the result

## Operation
- State: output stage EMPTY (res_valid=0) or FULL (res_valid=1). Round-robin pointer ptr (IDW bits) names the highest-priority requester.
- can_accept = EMPTY, or (FULL and res_ready). If can_accept is 0, req_ready is all-zero.
- Arbitration is combinational. When can_accept=1, grant the first i with req_valid[i]=1, scanning ptr, ptr+1, ... and wrapping modulo N_REQ. req_ready[i]=1 only for the granted i. Bits of req_valid at or above N_REQ do not exist, and non-power-of-2 N_REQ wraps at N_REQ-1 to 0.
- A transfer occurs when req_valid[i] and req_ready[i] are both 1. On that edge:
  - the granted operands drive the adder;
  - res_sum, res_co, res_ovf and res_id are loaded; res_valid is set to 1;
  - ptr is set to (i+1) mod N_REQ.
- Overflow: res_ovf = (a[23]==b[23]) and (s[23]!=a[23]). The carry-in is included in s.
- If no transfer occurs and FULL and res_ready=1, the stage goes to EMPTY. The res_* data fields hold their last values.
- If FULL and res_ready=0, all res_* outputs hold stable.
- ptr changes only on a transfer.
- Requester obligations, checked by assertion: once req_valid[i]=1, it stays high and the operands stay stable until accepted.
- Fairness: a requester holding valid is accepted within N_REQ transfers.

## Timing
- Latency: a request accepted at edge k shows res_valid=1 and its data after edge k.
- Throughput: one result per cycle while res_ready=1.
- Simultaneous drain and accept in one cycle: the result register is overwritten and res_valid stays 1, with no bubble.
- req_ready depends combinationally on req_valid, ptr, res_valid and res_ready. res_* outputs are driven from registers only.
- Reset, asynchronous at assertion: res_valid=0, res_sum=0, res_co=0, res_ovf=0, res_id=0, ptr=0, req_ready=0.
- Reset mid-operation discards the held result and any pending grant. The first grant after deassertion starts from requester 0.

## Test plan
- Single request: requester 2 sends a=0x7FFFFF, b=0x000001, ci=0, res_ready=1 -> next cycle res_valid=1, res_sum=0x800000, res_co=0, res_ovf=1, res_id=2.
- Carry-out without overflow: a=0xFFFFFF, b=0x000001, ci=1 -> res_sum=0x000001, res_co=1, res_ovf=0.
- Round-robin: all 4 requesters valid continuously, res_ready=1 -> res_id sequence 0,1,2,3,0,1,… with one result per cycle and no requester skipped.
- Backpressure: res_ready=0 for 5 cycles with requests pending -> after the first load, req_ready=0 and res_* hold stable. When res_ready=1, the next grant is accepted in that same cycle, with no bubble.
- Pointer wrap with sparse requests: only requesters 3 and 0 valid, ptr=1 -> grant 3, then 0, then 3.
- Reset mid-stream: assert rst while res_valid=1 and ptr=2 -> res_valid=0 and all res_* outputs are 0 immediately, without waiting for a clock. After release, the first grant goes to the lowest valid index.
